// File: rtl/dma_multi_if.sv
// CPU register port and system bus of the multi-channel DMA engine.
// CPU: i_request is held until o_ready=1; o_ready drops the cycle after i_request drops. Bus: request and payload stay stable until i_bus_ready=1.
`timescale 1ns/1ps
interface dma_multi_if #(parameter int CHANNELS = 2);
  localparam int AW = $clog2(CHANNELS) + 2;

  logic          i_request;
  logic          i_rw;
  logic [AW-1:0] i_address;
  logic [31:0]   i_wdata;
  logic [31:0]   o_rdata;
  logic          o_ready;
  logic          i_stall;
  logic          o_bus_rw;
  logic          o_bus_request;
  logic          i_bus_ready;
  logic [31:0]   o_bus_address;
  logic [31:0]   o_bus_wdata;
  logic [31:0]   i_bus_rdata;
  logic          o_irq;

  modport master (
    output i_request, i_rw, i_address, i_wdata, i_stall, i_bus_ready, i_bus_rdata,
    input  o_rdata, o_ready, o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_irq
  );

  modport slave (
    input  i_request, i_rw, i_address, i_wdata, i_stall, i_bus_ready, i_bus_rdata,
    output o_rdata, o_ready, o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata, o_irq
  );
endinterface

// File: rtl/dma_multi.sv
// Multi-channel FILL/COPY DMA engine: one word per round-robin grant, CPU-programmed per-channel registers.
`timescale 1ns/1ps
module dma_multi #(
  parameter int CHANNELS = 2,
  parameter int STEP     = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  dma_multi_if.slave  bus,
  output logic [2:0]  o_dbg_state
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_ch_q, cur_ch_d, last_ch_q, last_ch_d;
  logic [31:0]   data_q, data_d, rdata_q, rdata_d;
  logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic          ready_q, ready_d, bus_req_q, bus_req_d, bus_rw_q, bus_rw_d;

  logic [31:0]   src_q [CHANNELS];
  logic [31:0]   src_d [CHANNELS];
  logic [31:0]   dst_q [CHANNELS];
  logic [31:0]   dst_d [CHANNELS];
  logic [31:0]   cnt_q [CHANNELS];
  logic [31:0]   cnt_d [CHANNELS];
  logic [CHANNELS-1:0] busy_q, busy_d, done_q, done_d, irq_en_q, irq_en_d;
  logic [CHANNELS-1:0] src_fix_q, src_fix_d, dst_fix_q, dst_fix_d;
  logic [CHANNELS-1:0] copy_q, copy_d, abort_q, abort_d;

  logic [CHANNELS-1:0] elig;
  logic [CW-1:0] cand, sel_ch, acc_idx;
  logic          sel_found, access, engine_owns;
  logic [31:0]   addr_ext;
  int            acc_ch;
  logic [1:0]    acc_reg, mode;

  always_comb begin
    state_d     = state_q;
    cur_ch_d    = cur_ch_q;
    last_ch_d   = last_ch_q;
    data_d      = data_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    irq_en_d    = irq_en_q;
    src_fix_d   = src_fix_q;
    dst_fix_d   = dst_fix_q;
    copy_d      = copy_q;
    abort_d     = abort_q;
    rdata_d     = rdata_q;
    ready_d     = bus.i_request;
    access      = bus.i_request && !ready_q;
    addr_ext    = 32'(bus.i_address);
    acc_ch      = int'(addr_ext >> 2);
    acc_reg     = addr_ext[1:0];
    acc_idx     = CW'(acc_ch);
    mode        = bus.i_wdata[1:0];
    cand        = '0;
    sel_ch      = last_ch_q;
    sel_found   = 1'b0;

    // A zero-count start never enters the engine; it simply completes.
    for (int c = 0; c < CHANNELS; c++) begin
      elig[c] = busy_q[c] && (cnt_q[c] != 32'd0);
      if (busy_q[c] && (cnt_q[c] == 32'd0)) begin
        busy_d[c] = 1'b0;
        done_d[c] = 1'b1;
      end
    end

    for (int k = 1; k <= CHANNELS; k++) begin
      cand = CW'((int'(last_ch_q) + k) % CHANNELS);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end

    case (state_q)
      S_IDLE: if (|elig) state_d = S_ARB;
      S_ARB: begin
        if (sel_found) begin
          cur_ch_d  = sel_ch;
          last_ch_d = sel_ch;
          state_d   = copy_q[sel_ch] ? S_RD_REQ : S_WR_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (abort_q[cur_ch_q]) begin
          busy_d[cur_ch_q]  = 1'b0;
          abort_d[cur_ch_q] = 1'b0;
          state_d           = S_IDLE;
        end else if (!bus.i_stall) begin
          bus_req_d  = 1'b1;
          bus_rw_d   = 1'b0;
          bus_addr_d = src_q[cur_ch_q];
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.i_bus_ready) begin
          bus_req_d = 1'b0;
          data_d    = bus.i_bus_rdata;
          if (!src_fix_q[cur_ch_q]) src_d[cur_ch_q] = src_q[cur_ch_q] + 32'(STEP);
          if (abort_q[cur_ch_q]) begin
            busy_d[cur_ch_q]  = 1'b0;
            abort_d[cur_ch_q] = 1'b0;
            state_d           = S_IDLE;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (abort_q[cur_ch_q]) begin
          busy_d[cur_ch_q]  = 1'b0;
          abort_d[cur_ch_q] = 1'b0;
          state_d           = S_IDLE;
        end else if (!bus.i_stall) begin
          bus_req_d   = 1'b1;
          bus_rw_d    = 1'b1;
          bus_addr_d  = dst_q[cur_ch_q];
          bus_wdata_d = copy_q[cur_ch_q] ? data_q : src_q[cur_ch_q];
          state_d     = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (bus.i_bus_ready) begin
          bus_req_d = 1'b0;
          if (!dst_fix_q[cur_ch_q]) dst_d[cur_ch_q] = dst_q[cur_ch_q] + 32'(STEP);
          cnt_d[cur_ch_q] = cnt_q[cur_ch_q] - 32'd1;
          if (cnt_q[cur_ch_q] == 32'd1) begin
            done_d[cur_ch_q] = 1'b1;
            busy_d[cur_ch_q] = 1'b0;
          end
          if (abort_q[cur_ch_q]) begin
            busy_d[cur_ch_q]  = 1'b0;
            done_d[cur_ch_q]  = 1'b0;
            abort_d[cur_ch_q] = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An abort on the channel the engine is working on is deferred to the end of its transaction.
    engine_owns = (state_d inside {S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT}) && (cur_ch_d == acc_idx);

    if (access && (acc_ch < CHANNELS)) begin
      if (bus.i_rw) begin
        case (acc_reg)
          2'd0: if (!busy_q[acc_idx]) src_d[acc_idx] = bus.i_wdata;
          2'd1: if (!busy_q[acc_idx]) dst_d[acc_idx] = bus.i_wdata;
          2'd2: if (!busy_q[acc_idx]) cnt_d[acc_idx] = bus.i_wdata;
          default: begin
            if (mode == 2'd0) begin
              done_d[acc_idx]   = 1'b0;
              irq_en_d[acc_idx] = bus.i_wdata[4];
              if (busy_d[acc_idx]) begin
                if (engine_owns) abort_d[acc_idx] = 1'b1;
                else             busy_d[acc_idx]  = 1'b0;
              end
            end else if ((mode != 2'd3) && !busy_q[acc_idx]) begin
              busy_d[acc_idx]    = 1'b1;
              done_d[acc_idx]    = 1'b0;
              copy_d[acc_idx]    = (mode == 2'd2);
              src_fix_d[acc_idx] = bus.i_wdata[2];
              dst_fix_d[acc_idx] = bus.i_wdata[3];
              irq_en_d[acc_idx]  = bus.i_wdata[4];
            end
          end
        endcase
      end else begin
        case (acc_reg)
          2'd0:    rdata_d = src_q[acc_idx];
          2'd1:    rdata_d = dst_q[acc_idx];
          2'd2:    rdata_d = cnt_q[acc_idx];
          default: rdata_d = {27'b0, irq_en_q[acc_idx], 2'b0, done_q[acc_idx], busy_q[acc_idx]};
        endcase
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      cur_ch_q    <= '0;
      last_ch_q   <= CW'(CHANNELS - 1);
      data_q      <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        src_q[c] <= '0;
        dst_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      busy_q    <= '0;
      done_q    <= '0;
      irq_en_q  <= '0;
      src_fix_q <= '0;
      dst_fix_q <= '0;
      copy_q    <= '0;
      abort_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      last_ch_q   <= last_ch_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      irq_en_q    <= irq_en_d;
      src_fix_q   <= src_fix_d;
      dst_fix_q   <= dst_fix_d;
      copy_q      <= copy_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_bus_request = bus_req_q;
  assign bus.o_bus_rw      = bus_rw_q;
  assign bus.o_bus_address = bus_addr_q;
  assign bus.o_bus_wdata   = bus_wdata_q;
  assign bus.o_irq         = |(done_q & irq_en_q);
  assign o_dbg_state       = state_q;
endmodule

// File: tb/tb_dma_multi.sv
// Directed bench for dma_multi: CPU register tasks, a fixed-latency bus responder and a transaction scoreboard.
`timescale 1ns/1ps
module tb_dma_multi;
  localparam int AW  = 3;
  localparam int LAT = 3;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_RD_WAIT = 3'd3, ST_WR_REQ = 3'd4, ST_WR_WAIT = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;
  int         lat_cnt  = 0;
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  logic [31:0] rd;

  dma_multi_if #(.CHANNELS(2)) bus();

  dma_multi #(.CHANNELS(2), .STEP(4)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Bus responder: acknowledges after LAT negedges, logs {rw, addr, data}.
  always @(negedge clk) begin
    if (bus.i_bus_ready) begin
      bus.i_bus_ready = 1'b0;
    end else if (bus.o_bus_request && rst_n) begin
      lat_cnt++;
      if (lat_cnt >= LAT) begin
        lat_cnt = 0;
        bus.i_bus_ready = 1'b1;
        if (!bus.o_bus_rw) bus.i_bus_rdata = bus.o_bus_address ^ 32'h5A5A_0000;
        obs_q.push_back({bus.o_bus_rw, bus.o_bus_address,
                         bus.o_bus_rw ? bus.o_bus_wdata : bus.i_bus_rdata});
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // driver tasks
  task automatic cpu_access(input logic rw, input int ch, input int rg,
                            input logic [31:0] wd, output logic [31:0] rdv);
    int n;
    bus.i_request = 1'b1;
    bus.i_rw      = rw;
    bus.i_address = AW'(ch * 4 + rg);
    bus.i_wdata   = wd;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.o_ready) check("cpu_ack", 65'(bus.o_ready), 65'd1);
    rdv = bus.o_rdata;
    bus.i_request = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.o_ready && n < 20) begin @(negedge clk); n++; end
    if (bus.o_ready) check("cpu_release", 65'(bus.o_ready), 65'd0);
  endtask

  task automatic cpu_write(input int ch, input int rg, input logic [31:0] wd);
    logic [31:0] dummy;
    cpu_access(1'b1, ch, rg, wd, dummy);
  endtask

  task automatic cpu_read(input int ch, input int rg, output logic [31:0] rdv);
    cpu_access(1'b0, ch, rg, 32'd0, rdv);
  endtask

  task automatic wait_idle(input int ch, input string tag);
    logic [31:0] r;
    int n = 0;
    cpu_read(ch, 3, r);
    while (r[0] && n < 100) begin cpu_read(ch, 3, r); n++; end
    if (r[0]) check(tag, 65'(r[0]), 65'd0);
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int n = 0;
    while (dbg_state != st && n < 200) begin @(negedge clk); n++; end
    if (dbg_state != st) check(tag, 65'(dbg_state), 65'(st));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_txn(input logic rw, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({rw, a, d});
  endtask

  task automatic check_txns(input string tag);
    check({tag, "_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int n;
    int req_seen;
    rst_n = 1'b0;
    bus.i_request = 1'b0; bus.i_rw = 1'b0; bus.i_address = '0; bus.i_wdata = '0;
    bus.i_stall = 1'b0; bus.i_bus_ready = 1'b0; bus.i_bus_rdata = '0;
    wait_cycles(3);
    check("rst_ready",   65'(bus.o_ready), 65'd0);
    check("rst_req",     65'(bus.o_bus_request), 65'd0);
    check("rst_rw",      65'(bus.o_bus_rw), 65'd0);
    check("rst_irq",     65'(bus.o_irq), 65'd0);
    check("rst_rdata",   65'(bus.o_rdata), 65'd0);
    check("rst_addr",    65'(bus.o_bus_address), 65'd0);
    check("rst_wdata",   65'(bus.o_bus_wdata), 65'd0);
    check("rst_state",   65'(dbg_state), 65'(ST_IDLE));
    rst_n = 1'b1;
    wait_cycles(2);

    // FILL ch0
    cpu_write(0, 0, 32'hDEAD_BEEF);
    cpu_write(0, 1, 32'h0000_1000);
    cpu_write(0, 2, 32'd3);
    cpu_write(0, 3, 32'h1);
    wait_idle(0, "fill_busy_timeout");
    expect_txn(1'b1, 32'h1000, 32'hDEAD_BEEF);
    expect_txn(1'b1, 32'h1004, 32'hDEAD_BEEF);
    expect_txn(1'b1, 32'h1008, 32'hDEAD_BEEF);
    check_txns("fill");
    cpu_read(0, 3, rd); check("fill_ctrl", 65'(rd), 65'h2);
    cpu_read(0, 1, rd); check("fill_dst",  65'(rd), 65'h100C);
    cpu_read(0, 2, rd); check("fill_cnt",  65'(rd), 65'h0);

    // COPY ch1 with fixed destination
    cpu_write(1, 0, 32'h0000_2000);
    cpu_write(1, 1, 32'h0000_3000);
    cpu_write(1, 2, 32'd2);
    cpu_write(1, 3, 32'hA);
    wait_idle(1, "copy_busy_timeout");
    expect_txn(1'b0, 32'h2000, 32'h5A5A_2000);
    expect_txn(1'b1, 32'h3000, 32'h5A5A_2000);
    expect_txn(1'b0, 32'h2004, 32'h5A5A_2004);
    expect_txn(1'b1, 32'h3000, 32'h5A5A_2004);
    check_txns("copy");
    cpu_read(1, 3, rd); check("copy_ctrl", 65'(rd), 65'h2);
    cpu_read(1, 0, rd); check("copy_src",  65'(rd), 65'h2008);
    cpu_read(1, 1, rd); check("copy_dst",  65'(rd), 65'h3000);

    // Reserved mode is a no-op
    cpu_write(1, 3, 32'h3);
    wait_cycles(10);
    cpu_read(1, 3, rd); check("mode3_ctrl", 65'(rd), 65'h2);
    check_txns("mode3");

    // Round-robin between two FILL channels; writes to busy ch0 are ignored
    bus.i_stall = 1'b1;
    cpu_write(0, 0, 32'h1111_1111);
    cpu_write(0, 1, 32'h0000_4000);
    cpu_write(0, 2, 32'd2);
    cpu_write(1, 0, 32'h2222_2222);
    cpu_write(1, 1, 32'h0000_5000);
    cpu_write(1, 2, 32'd2);
    cpu_write(0, 3, 32'h1);
    cpu_write(1, 3, 32'h1);
    cpu_write(0, 1, 32'h0000_BAD0);
    cpu_write(0, 3, 32'h2);
    bus.i_stall = 1'b0;
    wait_idle(0, "rr0_busy_timeout");
    wait_idle(1, "rr1_busy_timeout");
    expect_txn(1'b1, 32'h4000, 32'h1111_1111);
    expect_txn(1'b1, 32'h5000, 32'h2222_2222);
    expect_txn(1'b1, 32'h4004, 32'h1111_1111);
    expect_txn(1'b1, 32'h5004, 32'h2222_2222);
    check_txns("rr");
    cpu_read(0, 1, rd); check("rr_dst0", 65'(rd), 65'h4008);

    // Address wraps modulo 2^32
    cpu_write(0, 0, 32'h0BAD_F00D);
    cpu_write(0, 1, 32'hFFFF_FFFC);
    cpu_write(0, 2, 32'd2);
    cpu_write(0, 3, 32'h1);
    wait_idle(0, "wrap_busy_timeout");
    expect_txn(1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D);
    expect_txn(1'b1, 32'h0000_0000, 32'h0BAD_F00D);
    check_txns("wrap");
    cpu_read(0, 1, rd); check("wrap_dst", 65'(rd), 65'h4);

    // Zero-count start with interrupt enabled
    check("irq_before", 65'(bus.o_irq), 65'd0);
    cpu_write(0, 2, 32'd0);
    cpu_write(0, 3, 32'h11);
    wait_cycles(5);
    check("zero_irq", 65'(bus.o_irq), 65'd1);
    cpu_read(0, 3, rd); check("zero_ctrl", 65'(rd), 65'h12);
    check_txns("zero");
    cpu_write(0, 3, 32'h10);
    check("zero_irq_clr", 65'(bus.o_irq), 65'd0);
    cpu_read(0, 3, rd); check("zero_ctrl_clr", 65'(rd), 65'h10);

    // Abort a COPY while its third read is in flight
    cpu_write(0, 0, 32'h0000_6000);
    cpu_write(0, 1, 32'h0000_7000);
    cpu_write(0, 2, 32'd8);
    cpu_write(0, 3, 32'h2);
    n = 0;
    while (!(obs_q.size() == 4 && dbg_state == ST_RD_WAIT) && n < 500) begin @(negedge clk); n++; end
    if (dbg_state != ST_RD_WAIT) check("abort_reach", 65'(dbg_state), 65'(ST_RD_WAIT));
    cpu_write(0, 3, 32'h0);
    wait_idle(0, "abort_busy_timeout");
    wait_cycles(30);
    expect_txn(1'b0, 32'h6000, 32'h5A5A_6000);
    expect_txn(1'b1, 32'h7000, 32'h5A5A_6000);
    expect_txn(1'b0, 32'h6004, 32'h5A5A_6004);
    expect_txn(1'b1, 32'h7004, 32'h5A5A_6004);
    expect_txn(1'b0, 32'h6008, 32'h5A5A_6008);
    check_txns("abort");
    cpu_read(0, 0, rd); check("abort_src",  65'(rd), 65'h600C);
    cpu_read(0, 1, rd); check("abort_dst",  65'(rd), 65'h7008);
    cpu_read(0, 2, rd); check("abort_cnt",  65'(rd), 65'd6);
    cpu_read(0, 3, rd); check("abort_ctrl", 65'(rd), 65'h0);

    // Stall in WR_REQ, then reset in the middle of WR_WAIT
    bus.i_stall = 1'b1;
    cpu_write(1, 0, 32'hCAFE_F00D);
    cpu_write(1, 1, 32'h0000_8000);
    cpu_write(1, 2, 32'd4);
    cpu_write(1, 3, 32'h1);
    wait_state(ST_WR_REQ, "stall_reach");
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_bus_request) req_seen++;
    end
    check("stall_noreq", 65'(req_seen), 65'd0);
    check("stall_state", 65'(dbg_state), 65'(ST_WR_REQ));
    bus.i_stall = 1'b0;
    wait_state(ST_WR_WAIT, "wrwait_reach");
    check("wr_req",   65'(bus.o_bus_request), 65'd1);
    check("wr_addr",  65'(bus.o_bus_address), 65'h8000);
    check("wr_wdata", 65'(bus.o_bus_wdata), 65'hCAFE_F00D);
    rst_n = 1'b0;
    #1;
    check("rst_async_req",  65'(bus.o_bus_request), 65'd0);
    check("rst_async_addr", 65'(bus.o_bus_address), 65'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    req_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_bus_request) req_seen++;
    end
    check("post_rst_noreq", 65'(req_seen), 65'd0);
    check("post_rst_state", 65'(dbg_state), 65'(ST_IDLE));
    check_txns("post_rst");
    cpu_read(1, 3, rd); check("post_rst_ctrl", 65'(rd), 65'h0);
    cpu_read(1, 1, rd); check("post_rst_dst",  65'(rd), 65'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dma_multi.md
DMA_MULTI -- requirements
Module: dma_multi

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent DMA channels (legal 1..8).
REQ-002 Parameter STEP, default 4, byte increment applied to an incrementing address per word.
REQ-003 i_clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 i_reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_request  in  1  CPU register access request.
REQ-006 i_rw  in  1  1 = write, 0 = read.
REQ-007 i_address  in  $clog2(CHANNELS)+2  {channel, reg}; reg 0 SRC/VALUE, 1 DST, 2 COUNT, 3 CTRL.
REQ-008 i_wdata  in  32  CPU write data.
REQ-009 o_rdata  out  32  CPU read data.
REQ-010 o_ready  out  1  CPU access acknowledge.
REQ-011 i_stall  in  1  system stall; blocks new bus requests.
REQ-012 o_bus_rw, o_bus_request  out  1 each  bus direction, bus request.
REQ-013 i_bus_ready  in  1  bus transaction complete.
REQ-014 o_bus_address, o_bus_wdata  out  32 each; i_bus_rdata  in  32.
REQ-015 o_irq  out  1  level interrupt = OR over channels of (done & irq_en).

Function
REQ-016 CPU access: side effect occurs in the cycle i_request=1 and o_ready=0; o_ready goes 1 next cycle and stays 1 while i_request=1; o_ready goes 0 the cycle after i_request=0; exactly one side effect per request.
REQ-017 CTRL write bits: [1:0] mode (0 abort, 1 FILL, 2 COPY, 3 reserved = no-op); bit2 src_fixed; bit3 dst_fixed; bit4 irq_en.
REQ-018 CTRL write with mode 1/2 on an idle channel: latches SRC/DST/COUNT into working copies, clears done, sets busy.
REQ-019 CTRL write with mode 1/2 on a busy channel is ignored (still acknowledged).
REQ-020 CTRL write with mode 0: clears done; a busy channel stops after its in-flight bus transaction completes, then busy=0, done=0.
REQ-021 SRC/DST/COUNT writes to a busy channel are ignored; to an idle channel they load the register.
REQ-022 Reads: reg 0/1/2 return live working value (remaining count for COUNT); CTRL read returns {27'b0, irq_en, 2'b0, done, busy} at bits [4],[1],[0].
REQ-023 COUNT = number of 32-bit words; start with COUNT=0 sets done, clears busy next cycle, issues no bus traffic.
REQ-024 Engine states: IDLE, ARB, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-025 IDLE->ARB when any channel busy; ARB selects next busy channel round-robin starting after the last-served channel (one word per grant).
REQ-026 ARB->RD_REQ for COPY, ->WR_REQ for FILL; RD_REQ/WR_REQ assert o_bus_request only when i_stall=0, else hold state.
REQ-027 o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata stay constant from assertion until the cycle i_bus_ready=1; o_bus_request deasserts next cycle.
REQ-028 RD_WAIT: on i_bus_ready capture i_bus_rdata, SRC += STEP unless src_fixed, go WR_REQ.
REQ-029 WR_WAIT: on i_bus_ready DST += STEP unless dst_fixed, COUNT -= 1; if COUNT reaches 0 set done, clear busy; go IDLE.
REQ-030 FILL writes the SRC/VALUE word unchanged to every destination.
REQ-031 Address arithmetic is modulo 2^32 (wrap 0xFFFFFFFC + 4 = 0x00000000).
REQ-032 CPU access and engine update to the same channel in the same cycle: engine update to working registers takes effect; CPU abort is honoured per REQ-020.
REQ-033 Abort during RD_WAIT: write phase is skipped; SRC has advanced, DST/COUNT unchanged.

Reset
REQ-034 While i_reset_n=0: state IDLE, all channels busy=0, done=0, irq_en=0, registers 0; o_ready, o_bus_request, o_bus_rw, o_irq = 0; o_rdata, o_bus_address, o_bus_wdata = 0.
REQ-035 Reset asserted mid-transfer drops o_bus_request immediately (asynchronously); no resumption after release.

Verification
REQ-036 Ch0 FILL VALUE=0xDEADBEEF DST=0x1000 COUNT=3 -> writes to 0x1000/0x1004/0x1008, then CTRL read = 0x2.
REQ-037 Ch1 COPY SRC=0x2000 DST=0x3000 COUNT=2, dst_fixed=1 -> reads 0x2000, 0x2004; both writes to 0x3000.
REQ-038 Ch0 and Ch1 each FILL COUNT=2 started same cycle -> bus writes alternate ch0, ch1, ch0, ch1.
REQ-039 COUNT=0, irq_en=1 start -> no bus request, done=1, o_irq=1; CTRL write mode 0 -> o_irq=0.
REQ-040 Abort ch0 during COPY COUNT=8 after 2 words -> in-flight transaction completes, no further requests, COUNT reads 6, busy=0.
REQ-041 i_stall=1 during WR_REQ for 5 cycles, then i_reset_n pulsed low mid-WR_WAIT -> no request while stalled; o_bus_request 0 at once on reset.
